// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
package arb_pkg;

    // Upper bound on requester count that onehot_to_idx can decode.
    localparam int ARB_MAX_N = 64;

    // Per-cycle decision taken by the arbiter.
    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,
        ACT_KEEP = 2'd1,
        ACT_ARB  = 2'd2
    } arb_act_e;

    // Index of the set bit in a one-hot vector (zero-extended to ARB_MAX_N).
    // An all-zero vector decodes to 0.
    function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_hold_pick.sv
// Cyclic first-set search: lowest set bit of req at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [2*N-1:0] req2;

    // Doubled request vector masked below ptr; first hit in the upper copy
    // is a wrapped winner, folded back by subtracting N.
    always_comb begin
        req2    = {req, req};
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!any && req2[j] && (j >= int'(ptr))) begin
                any                           = 1'b1;
                win_idx                       = IDX_W'((j >= N) ? (j - N) : j);
                win_oh[(j >= N) ? (j - N) : j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_hold.sv
// Round-robin arbiter with registered one-hot grant and bounded burst lock.
module rr_arb_hold
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req_in,
    output logic [N-1:0]     grant_out,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

    logic [N-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N-1:0]      win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              pick_any;
    logic [N-1:0]      others;
    logic              keep_ok;
    arb_act_e          act;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_in),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (pick_any)
    );

    // Decide KEEP / ARBITRATE / IDLE and form the next state. Since ptr_q
    // already points past the owner, a forced rotation needs no masking.
    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        others  = req_in & ~grant_q;
        keep_ok = (|(req_in & grant_q)) && ((hold_q < HOLD_LAST) || (others == '0));
        act     = ACT_IDLE;
        if (!pick_any)    act = ACT_IDLE;
        else if (keep_ok) act = ACT_KEEP;
        else              act = ACT_ARB;

        case (act)
            ACT_KEEP: begin
                if (hold_q < HOLD_LAST) hold_d = hold_q + 1'b1;
            end
            ACT_ARB: begin
                grant_d = win_oh;
                ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                hold_d  = '0;
            end
            default: begin
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State registers; reset overrides any burst in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs decoded from the grant flop, so they align with grant_out.
    always_comb begin
        grant_out   = grant_q;
        grant_valid = |grant_q;
        grant_idx   = IDX_W'(onehot_to_idx(ARB_MAX_N'(grant_q)));
    end

endmodule
